// File: rtl/ecc_sector_sequencer.sv
// Byte sequencer for the ECC generator: walks SECTORS sectors of the page buffer,
// serialising each WORD_BYTES-wide word LSB-byte-first with a per-sector byte index.
module ecc_sector_sequencer #(
  parameter int unsigned  WORD_BYTES   = 4,
  parameter int unsigned  SECTOR_BYTES = 512,
  parameter int unsigned  SECTORS      = 4,
  localparam int unsigned CW           = $clog2(SECTOR_BYTES),
  localparam int unsigned WPS          = SECTOR_BYTES / WORD_BYTES,
  localparam int unsigned AW_RAW       = $clog2(SECTORS * WPS),
  localparam int unsigned AW           = (AW_RAW < 1) ? 1 : AW_RAW,
  localparam int unsigned SW           = (SECTORS < 2) ? 1 : $clog2(SECTORS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      hold,
  output logic [AW-1:0]             rd_addr,
  input  logic [8*WORD_BYTES-1:0]   rd_data,
  output logic [7:0]                data8,
  output logic [CW-1:0]             count,
  output logic                      ecc_gen,
  output logic                      reset_gen,
  output logic                      ecc_load,
  output logic [SW-1:0]             sector_idx,
  output logic                      sector_done,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned   PW          = $clog2(WORD_BYTES);
  localparam logic [SW-1:0] LAST_SECTOR = SW'(SECTORS - 1);
  localparam logic [CW-1:0] LAST_BYTE   = CW'(SECTOR_BYTES - 1);
  localparam logic [PW-1:0] LAST_PTR    = PW'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_FETCH,
    S_SHIFT,
    S_LOAD,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           rd_addr_q, rd_addr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [SW-1:0]           sector_idx_q, sector_idx_d;
  logic [8*WORD_BYTES-1:0] word_q, word_d;
  logic [PW-1:0]           ptr;
  logic                    addr_more;

  function automatic logic [AW-1:0] sector_base(input logic [SW-1:0] idx);
    return AW'(32'(idx) * WPS);
  endfunction

  // Byte pointer is the low bits of the in-sector byte index.
  assign ptr = count_q[PW-1:0];

  // rd_addr stops on the sector's last word so no read goes past the page.
  assign addr_more = (32'(rd_addr_q) % WPS) != (WPS - 32'd1);

  assign rd_addr     = rd_addr_q;
  assign count       = count_q;
  assign sector_idx  = sector_idx_q;
  assign data8       = word_q[{ptr, 3'b000} +: 8];
  assign ecc_gen     = (state_q == S_SHIFT) && !hold;
  assign reset_gen   = (state_q == S_IDLE) || (state_q == S_RESET);
  assign ecc_load    = (state_q == S_LOAD);
  assign sector_done = (state_q == S_LOAD);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    count_d      = count_q;
    sector_idx_d = sector_idx_q;
    word_d       = word_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_RESET;
          sector_idx_d = '0;
          rd_addr_d    = '0;
        end
      end
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        word_d  = rd_data;
        count_d = '0;
        if (addr_more) rd_addr_d = rd_addr_q + 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (!hold) begin
          if (count_q == LAST_BYTE) begin
            state_d = S_LOAD;
          end else begin
            count_d = count_q + 1'b1;
            // Next word was prefetched while this one was shifting out.
            if (ptr == LAST_PTR) begin
              word_d = rd_data;
              if (addr_more) rd_addr_d = rd_addr_q + 1'b1;
            end
          end
        end
      end
      S_LOAD: begin
        if (sector_idx_q == LAST_SECTOR) begin
          state_d = S_DONE;
        end else begin
          sector_idx_d = sector_idx_q + 1'b1;
          rd_addr_d    = sector_base(sector_idx_q + 1'b1);
          state_d      = S_RESET;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d      = S_IDLE;
      sector_idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rd_addr_q    <= '0;
      count_q      <= '0;
      sector_idx_q <= '0;
      word_q       <= '0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      count_q      <= count_d;
      sector_idx_q <= sector_idx_d;
      word_q       <= word_d;
    end
  end

endmodule

// File: tb/tb_ecc_sector_sequencer.sv
// Bench for ecc_sector_sequencer: page-level byte-stream scoreboard on the default
// configuration plus a second 8-byte-word, single-sector instance.
module tb_ecc_sector_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic start = 1'b0, abort = 1'b0, hold = 1'b0;
  logic start_b = 1'b0, abort_b = 1'b0, hold_b = 1'b0;

  logic [8:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  data8;
  logic [8:0]  count;
  logic        ecc_gen, reset_gen, ecc_load, sector_done, busy, done;
  logic [1:0]  sector_idx;

  logic [4:0]  rd_addr_b;
  logic [63:0] rd_data_b;
  logic [7:0]  data8_b;
  logic [7:0]  count_b;
  logic        ecc_gen_b, reset_gen_b, ecc_load_b, sector_done_b, busy_b, done_b;
  logic [0:0]  sector_idx_b;

  ecc_sector_sequencer #(.WORD_BYTES(4), .SECTOR_BYTES(512), .SECTORS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
    .rd_addr(rd_addr), .rd_data(rd_data), .data8(data8), .count(count),
    .ecc_gen(ecc_gen), .reset_gen(reset_gen), .ecc_load(ecc_load),
    .sector_idx(sector_idx), .sector_done(sector_done), .busy(busy), .done(done)
  );

  ecc_sector_sequencer #(.WORD_BYTES(8), .SECTOR_BYTES(256), .SECTORS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .hold(hold_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .data8(data8_b), .count(count_b),
    .ecc_gen(ecc_gen_b), .reset_gen(reset_gen_b), .ecc_load(ecc_load_b),
    .sector_idx(sector_idx_b), .sector_done(sector_done_b), .busy(busy_b), .done(done_b)
  );

  // Page buffers: synchronous read, byte k of word n holds (WORD_BYTES*n + k) mod 256.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) rd_data[8*k +: 8] <= 8'(32'(rd_addr) * 4 + k);
    for (int k = 0; k < 8; k++) rd_data_b[8*k +: 8] <= 8'(32'(rd_addr_b) * 8 + k);
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Page-level model: exp_g is the page byte number the next accepted byte must carry.
  int  exp_g = 0, sec_bytes = 0, loads = 0, dones = 0;
  int  cur_len = 0, last_len = 0;
  logic in_sec;

  always @(negedge clk) begin
    in_sec = busy && (sec_bytes > 0) && (sec_bytes < 512);
    chk("sector_done_with_load", sector_done, ecc_load);
    chk("rd_addr_in_page", rd_addr <= 9'd511, 1);
    chk("no_gen_while_hold", hold && ecc_gen, 0);
    if (!busy) chk("idle_reset_gen", reset_gen, 1);
    if (ecc_gen) begin
      chk("data8", data8, exp_g % 256);
      chk("count", count, exp_g % 512);
      chk("sector_idx", sector_idx, exp_g / 512);
      chk("reset_gen_in_stream", reset_gen, 0);
      exp_g++;
      sec_bytes++;
    end else if (in_sec) begin
      if (hold) begin
        chk("data8_frozen", data8, exp_g % 256);
        chk("count_frozen", count, exp_g % 512);
      end else begin
        chk("gen_contiguous", ecc_gen, 1);
      end
    end
    if (ecc_load) begin
      chk("sector_byte_total", sec_bytes, 512);
      chk("load_sector_idx", sector_idx, loads);
      loads++;
      sec_bytes = 0;
    end
    if (done) begin
      chk("done_after_loads", loads, 4);
      chk("done_byte_total", exp_g, 2048);
      dones++;
    end
    if (busy) cur_len++;
    else if (cur_len > 0) begin
      last_len = cur_len;
      cur_len  = 0;
    end
  end

  task automatic clr_model();
    exp_g = 0; sec_bytes = 0; loads = 0; dones = 0;
  endtask

  task automatic pulse_start(input logic with_abort);
    @(posedge clk); #1;
    start = 1'b1; abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int cyc = 0;
    while (busy && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    chk("run_completes", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_byte(input int sec, input int cnt);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(ecc_gen && sector_idx == 2'(sec) && count == 9'(cnt)) && cyc < 5000);
    chk("reach_byte", ecc_gen && sector_idx == 2'(sec) && count == 9'(cnt), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, len_b, nb, loads_b, dones_b, max_b;

    // Asynchronous reset values, no clock edge yet.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_reset_gen", reset_gen, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_data8", data8, 0);
    chk("rst_count", count, 0);
    chk("rst_sector_idx", sector_idx, 0);
    chk("rst_ecc_gen", ecc_gen, 0);
    chk("rst_ecc_load", ecc_load, 0);
    chk("rst_done", done, 0);
    #20 rst_n = 1'b1;

    // Full page, no hold.
    clr_model();
    pulse_start(1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ecc_gen && lat < 10);
    chk("first_gen_latency", lat, 3);
    chk("first_data8", data8, 8'h00);
    wait_idle(3000);
    chk("t1_busy_cycles", last_len, 2061);
    chk("t1_loads", loads, 4);
    chk("t1_dones", dones, 1);
    chk("t1_bytes", exp_g, 2048);

    // Three-cycle hold on byte 5.
    clr_model();
    pulse_start(1'b0);
    wait_byte(0, 4);
    @(posedge clk); #1 hold = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold_data8", data8, 8'h05);
      chk("hold_count", count, 5);
      chk("hold_gen", ecc_gen, 0);
    end
    @(posedge clk); #1 hold = 1'b0;
    wait_idle(3000);
    chk("t2_busy_cycles", last_len, 2064);
    chk("t2_loads", loads, 4);
    chk("t2_bytes", exp_g, 2048);

    // Abort in sector 1 at byte 100, then a clean page.
    clr_model();
    pulse_start(1'b0);
    wait_byte(1, 99);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_reset_gen", reset_gen, 1);
    chk("abort_gen", ecc_gen, 0);
    chk("abort_sector_idx", sector_idx, 0);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    chk("abort_loads", loads, 1);
    chk("abort_dones", dones, 0);
    clr_model();
    pulse_start(1'b0);
    wait_idle(3000);
    chk("t3_busy_cycles", last_len, 2061);
    chk("t3_loads", loads, 4);
    chk("t3_dones", dones, 1);

    // Start while busy is ignored; start with abort in idle stays idle.
    clr_model();
    pulse_start(1'b0);
    repeat (700) @(negedge clk);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle(3000);
    chk("t5_busy_cycles", last_len, 2061);
    chk("t5_dones", dones, 1);
    chk("t5_loads", loads, 4);
    pulse_start(1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("start_abort_idle", busy, 0);
    end
    @(posedge clk); #1;
    chk("t5_no_extra_done", dones, 1);

    // Asynchronous reset mid-stream.
    clr_model();
    pulse_start(1'b0);
    wait_byte(0, 50);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_reset_gen", reset_gen, 1);
    chk("arst_gen", ecc_gen, 0);
    chk("arst_rd_addr", rd_addr, 0);
    chk("arst_data8", data8, 0);
    chk("arst_count", count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("arst_idle_busy", busy, 0);
    chk("arst_idle_reset_gen", reset_gen, 1);

    // 8-byte words, 256-byte single sector.
    len_b = 0; nb = 0; loads_b = 0; dones_b = 0; max_b = 0;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!busy_b) break;
      len_b++;
      if (ecc_gen_b) begin
        chk("b_data8", data8_b, nb % 256);
        chk("b_count", count_b, nb);
        nb++;
      end
      if (32'(rd_addr_b) > max_b) max_b = 32'(rd_addr_b);
      if (ecc_load_b) loads_b++;
      if (done_b) dones_b++;
    end
    chk("b_busy_cycles", len_b, 260);
    chk("b_bytes", nb, 256);
    chk("b_loads", loads_b, 1);
    chk("b_dones", dones_b, 1);
    chk("b_max_rd_addr", max_b, 31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
